// File: rtl/stack_pkg.sv
// Shared definitions for the stack instruction sequencer.
// Holds opcode encodings, error codes, the FSM state type, default sizing
// and small opcode classification helpers used by the sequencer and ALU.
package stack_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 16;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSHI = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_AND   = 3'b101;
    localparam logic [2:0] OP_NOT   = 3'b110;
    localparam logic [2:0] OP_DUP   = 3'b111;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP_A   = 3'd1,
        POP_B   = 3'd2,
        CAP_A   = 3'd3,
        CAP_B   = 3'd4,
        PUSH_R  = 3'd5,
        PUSH_R2 = 3'd6
    } state_t;

    // Number of stack entries an opcode consumes before producing a result.
    function automatic logic [1:0] op_operands(input logic [2:0] op);
        case (op)
            OP_POP, OP_NOT, OP_DUP: op_operands = 2'd1;
            OP_ADD, OP_SUB, OP_AND: op_operands = 2'd2;
            default:                op_operands = 2'd0;
        endcase
    endfunction

    // Opcodes whose net effect grows the stack by one entry.
    function automatic logic op_grows(input logic [2:0] op);
        op_grows = (op == OP_PUSHI) || (op == OP_DUP);
    endfunction

    function automatic logic op_is_binary(input logic [2:0] op);
        op_is_binary = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    // Opcodes whose result comes from the ALU.
    function automatic logic op_is_alu(input logic [2:0] op);
        op_is_alu = op_is_binary(op) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/stack_op_alu.sv
// Combinational ALU for the stack sequencer.
// Computes ADD (b+a), SUB (b-a), AND (b&a) and NOT (~a), modulo 2^DW.
// Optional macro STACK_OP_SEQ_FLAGS_EN adds carry/zero outputs.
// Ports:
//   op     in  3   opcode selecting the operation
//   a      in  DW  top-of-stack operand
//   b      in  DW  next-of-stack operand
//   result out DW  operation result
//   carry  out 1   carry-out (ADD) or borrow (SUB), else 0   [macro only]
//   zero   out 1   result == 0                               [macro only]
module stack_op_alu
    import stack_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
`ifdef STACK_OP_SEQ_FLAGS_EN
    output logic          carry,
    output logic          zero,
`endif
    output logic [DW-1:0] result
);

    logic [DW:0] sum;
    logic [DW:0] diff;
    logic        carry_int;

    always_comb begin
        sum       = {1'b0, b} + {1'b0, a};
        diff      = {1'b0, b} - {1'b0, a};
        result    = '0;
        carry_int = 1'b0;
        case (op)
            OP_ADD: begin
                result    = sum[DW-1:0];
                carry_int = sum[DW];
            end
            OP_SUB: begin
                result    = diff[DW-1:0];
                carry_int = diff[DW];
            end
            OP_AND:  result = b & a;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
    end

`ifdef STACK_OP_SEQ_FLAGS_EN
    assign carry = carry_int;
    assign zero  = (result == '0);
`else
    // Carry only feeds the optional flags; keep it referenced so the
    // default build carries no dangling logic.
    logic unused_carry;
    assign unused_carry = carry_int;
`endif

endmodule

// File: rtl/stack_op_sequencer.sv
// Stack instruction sequencer: accepts one stack command at a time, checks
// it against the tracked depth, then drives push/pop strobes to an external
// LIFO (registered read data) to execute it.
// Optional macro STACK_OP_SEQ_FLAGS_EN adds flag_z / flag_c outputs.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cmd_valid/op/imm      command input; cmd_ready high only in IDLE
//   stk_push/pop/din      stack strobes and write data (Moore outputs)
//   stk_dout              stack read data, valid the cycle after stk_pop
//   res_valid/res_data    one-cycle POP result
//   depth                 tracked entry count
//   err/err_code/err_clr  sticky error status and its clear
//   flag_z/flag_c         result flags of the last ALU op [macro only]
//
// state   | meaning
// IDLE    | waiting for a command, legality check at accept
// POP_A   | pop first operand
// POP_B   | pop second operand, capture first (A)
// CAP_A   | capture A; POP returns it here
// CAP_B   | capture second operand (B)
// PUSH_R  | push result / immediate / first DUP copy
// PUSH_R2 | push second DUP copy
module stack_op_sequencer
    import stack_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    input  logic [2:0]    cmd_op,
    input  logic [DW-1:0] cmd_imm,
    output logic          cmd_ready,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [DW-1:0] stk_din,
    input  logic [DW-1:0] stk_dout,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic [CW-1:0] depth,
`ifdef STACK_OP_SEQ_FLAGS_EN
    output logic          flag_z,
    output logic          flag_c,
`endif
    output logic          err,
    output logic [1:0]    err_code,
    input  logic          err_clr
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic          started;
    logic [2:0]    op_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] alu_res;
    logic          accept;
    logic          under;
    logic          over;
    logic          legal;

    // started keeps cmd_ready low until the first clock after reset release.
    assign cmd_ready = started && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign under     = accept && (depth < CW'(op_operands(cmd_op)));
    assign over      = accept && !under && op_grows(cmd_op) && (depth >= FULL);
    assign legal     = accept && !under && !over;

`ifdef STACK_OP_SEQ_FLAGS_EN
    logic alu_carry;
    logic alu_zero;
`endif

    stack_op_alu #(.DW(DW)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
`ifdef STACK_OP_SEQ_FLAGS_EN
        .carry  (alu_carry),
        .zero   (alu_zero),
`endif
        .result (alu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_din   = '0;
        res_valid = 1'b0;
        res_data  = '0;
        case (state)
            IDLE: begin
                if (legal) begin
                    case (cmd_op)
                        OP_NOP:   state_nxt = IDLE;
                        OP_PUSHI: state_nxt = PUSH_R;
                        default:  state_nxt = POP_A;
                    endcase
                end
            end
            POP_A: begin
                stk_pop   = 1'b1;
                state_nxt = op_is_binary(op_q) ? POP_B : CAP_A;
            end
            POP_B: begin
                stk_pop   = 1'b1;
                state_nxt = CAP_B;
            end
            CAP_A: begin
                if (op_q == OP_POP) begin
                    res_valid = 1'b1;
                    res_data  = stk_dout;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = PUSH_R;
                end
            end
            CAP_B: state_nxt = PUSH_R;
            PUSH_R: begin
                stk_push = 1'b1;
                if (op_q == OP_PUSHI) begin
                    stk_din = imm_q;
                end else if (op_q == OP_DUP) begin
                    stk_din = a_q;
                end else begin
                    stk_din = alu_res;
                end
                state_nxt = (op_q == OP_DUP) ? PUSH_R2 : IDLE;
            end
            PUSH_R2: begin
                stk_push  = 1'b1;
                stk_din   = a_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started  <= 1'b0;
            op_q     <= OP_NOP;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            depth    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            started <= 1'b1;
            if (accept) begin
                op_q  <= cmd_op;
                imm_q <= cmd_imm;
            end
            // A is the old top: read back in POP_B for binary ops, CAP_A otherwise.
            if (state == POP_B || state == CAP_A) begin
                a_q <= stk_dout;
            end
            if (state == CAP_B) begin
                b_q <= stk_dout;
            end
            if (stk_push) begin
                depth <= depth + 1'b1;
            end else if (stk_pop) begin
                depth <= depth - 1'b1;
            end
            // A fresh error takes priority over a simultaneous clear.
            if (under) begin
                err      <= 1'b1;
                err_code <= ERR_UNDER;
            end else if (over) begin
                err      <= 1'b1;
                err_code <= ERR_OVER;
            end else if (err_clr) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
        end
    end

`ifdef STACK_OP_SEQ_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == PUSH_R && op_is_alu(op_q)) begin
            flag_z <= alu_zero;
            flag_c <= alu_carry;
        end
    end
`endif

endmodule
